// File: rtl/frac_accumulator.sv
// Fractional (modulo-M) phase accumulator with a double-buffered increment/modulus
// configuration that switches over on a wrap edge, or at once while disabled.
module frac_accumulator #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] inc_in,
   input  logic [WIDTH-1:0] mod_in,
   output logic [WIDTH-1:0] acc,
   output logic             cout,
   output logic             upd_pend,
   output logic             cfg_err
);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] inc_a_q, inc_a_d, mod_a_q, mod_a_d;
   logic [WIDTH-1:0] inc_s_q, inc_s_d, mod_s_q, mod_s_d;
   logic             cout_q, cout_d;
   logic             upd_pend_q, upd_pend_d;
   logic             cfg_err_q, cfg_err_d;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   modulus;
   logic             wrap;
   logic             load_ok;
   logic             load_bad;
   logic             xfer;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
      sum      = {1'b0, acc_q} + {1'b0, inc_a_q};
      modulus  = (mod_a_q == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, mod_a_q};
      wrap     = en && (sum >= modulus);
      load_ok  = load && ((mod_in == '0) || (inc_in < mod_in));
      load_bad = load && !load_ok;
      xfer     = upd_pend_q && (wrap || !en);

      acc_d      = acc_q;
      cout_d     = wrap;
      inc_a_d    = inc_a_q;
      mod_a_d    = mod_a_q;
      inc_s_d    = inc_s_q;
      mod_s_d    = mod_s_q;
      upd_pend_d = upd_pend_q;
      cfg_err_d  = cfg_err_q;

      // sum - M reduced to WIDTH bits: M is congruent to mod_a modulo 2^WIDTH and the
      // true result is always below 2^WIDTH because inc_a < M.
      if (en) begin
         acc_d = wrap ? (acc_q + inc_a_q - mod_a_q) : (acc_q + inc_a_q);
      end

      if (xfer) begin
         inc_a_d    = inc_s_q;
         mod_a_d    = mod_s_q;
         upd_pend_d = 1'b0;
      end

      // A load on the transfer edge lands after the old shadow has moved across.
      if (load_ok) begin
         inc_s_d    = inc_in;
         mod_s_d    = mod_in;
         upd_pend_d = 1'b1;
         cfg_err_d  = 1'b0;
      end else if (load_bad) begin
         cfg_err_d  = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q      <= '0;
         cout_q     <= 1'b0;
         inc_a_q    <= '0;
         mod_a_q    <= '0;
         inc_s_q    <= '0;
         mod_s_q    <= '0;
         upd_pend_q <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         cout_q     <= cout_d;
         inc_a_q    <= inc_a_d;
         mod_a_q    <= mod_a_d;
         inc_s_q    <= inc_s_d;
         mod_s_q    <= mod_s_d;
         upd_pend_q <= upd_pend_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign acc      = acc_q;
   assign cout     = cout_q;
   assign upd_pend = upd_pend_q;
   assign cfg_err  = cfg_err_q;

endmodule
